// File: rtl/dp_pkg.sv
// Shared encodings for the J17 multi-cycle datapath: ALU codes, PC codes, FSM states.
// Pure declarations, no logic, so it carries no latency or backpressure.
package dp_pkg;

   localparam logic [3:0] ALU_PASS = 4'd0;
   localparam logic [3:0] ALU_ADD  = 4'd1;
   localparam logic [3:0] ALU_SUB  = 4'd2;
   localparam logic [3:0] ALU_MUL  = 4'd3;
   localparam logic [3:0] ALU_DIV  = 4'd4;
   localparam logic [3:0] ALU_MOD  = 4'd5;
   localparam logic [3:0] ALU_OR   = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_XOR  = 4'd8;
   localparam logic [3:0] ALU_NOT  = 4'd9;
   localparam logic [3:0] ALU_SHR  = 4'd10;
   localparam logic [3:0] ALU_SHL  = 4'd11;

   localparam logic [3:0] PC_NEXT  = 4'd0;
   localparam logic [3:0] PC_BEQ   = 4'd1;
   localparam logic [3:0] PC_BLT   = 4'd2;
   localparam logic [3:0] PC_BGT   = 4'd3;
   localparam logic [3:0] PC_BNE   = 4'd4;
   localparam logic [3:0] PC_BLE   = 4'd5;
   localparam logic [3:0] PC_BGE   = 4'd6;
   localparam logic [3:0] PC_BNZ   = 4'd7;
   localparam logic [3:0] PC_BZ    = 4'd8;
   localparam logic [3:0] PC_JREG  = 4'd9;
   localparam logic [3:0] PC_HALT  = 4'd10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD1,
      ST_RD2,
      ST_EXEC,
      ST_WB
   } state_t;

endpackage

// File: rtl/dp_multicycle_if.sv
// Decoder-side instruction handshake plus data-RAM port and status of the J17 datapath.
// master = decoder/RAM side, slave = datapath; instr_ready is the only backpressure.
interface dp_multicycle_if #(
   parameter int WIDTH  = 32,
   parameter int NREGS  = 8,
   parameter int IMM_W  = 21,
   parameter int ADDR_W = 10,
   parameter int PC_W   = 32
);
   localparam int RIDX = $clog2(NREGS);

   logic              instr_valid;
   logic              instr_ready;
   logic [3:0]        alucode;
   logic [3:0]        pc_control;
   logic [RIDX-1:0]   rd;
   logic [RIDX-1:0]   rs2;
   logic [RIDX-1:0]   rt;
   logic [IMM_W-1:0]  imm;
   logic              im_control;
   logic              flag;
   logic              flag1;
   logic              writecode;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [WIDTH-1:0]  mem_wdata;
   logic [WIDTH-1:0]  mem_rdata;
   logic [PC_W-1:0]   PC;
   logic [WIDTH-1:0]  result;
   logic              done;
   logic              err;

   modport master (
      output instr_valid, alucode, pc_control, rd, rs2, rt, imm,
             im_control, flag, flag1, writecode, mem_rdata,
      input  instr_ready, mem_addr, mem_we, mem_wdata, PC, result, done, err
   );

   modport slave (
      input  instr_valid, alucode, pc_control, rd, rs2, rt, imm,
             im_control, flag, flag1, writecode, mem_rdata,
      output instr_ready, mem_addr, mem_we, mem_wdata, PC, result, done, err
   );

endinterface

// File: rtl/dp_alu.sv
// Combinational unsigned ALU, zero latency; mul/div/mod exist only with DP_MULDIV_EN defined,
// otherwise those codes fall into the undefined-code path (all-ones, err_op).
module dp_alu
   import dp_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   input  logic [3:0]       alucode,
   output logic [WIDTH-1:0] result,
   output logic             err_op
);

   always_comb begin
      result = '0;
      err_op = 1'b0;
      case (alucode)
         ALU_PASS: result = num1;
         ALU_ADD:  result = num1 + num2;
         ALU_SUB:  result = num1 - num2;
`ifdef DP_MULDIV_EN
         ALU_MUL:  result = num1 * num2;
         ALU_DIV: begin
            if (num2 == '0) begin
               result = '1;
               err_op = 1'b1;
            end else begin
               result = num1 / num2;
            end
         end
         ALU_MOD: begin
            if (num2 == '0) begin
               result = '1;
               err_op = 1'b1;
            end else begin
               result = num1 % num2;
            end
         end
`endif
         ALU_OR:   result = num1 | num2;
         ALU_AND:  result = num1 & num2;
         ALU_XOR:  result = num1 ^ num2;
         ALU_NOT:  result = ~num1;
         ALU_SHR:  result = num1 >> 1;
         ALU_SHL:  result = num1 << 1;
         default: begin
            result = '1;
            err_op = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/dp_multicycle.sv
// J17 multi-cycle datapath: regfile, FSM, PC unit; accept->done 2 cycles +1 per RAM operand.
// instr_ready is high only in IDLE (no queueing); mul/div/mod gated by DP_MULDIV_EN in dp_alu.
module dp_multicycle
   import dp_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NREGS  = 8,
   parameter int IMM_W  = 21,
   parameter int ADDR_W = 10,
   parameter int PC_W   = 32
) (
   input  logic           clock,
   input  logic           reset,
   dp_multicycle_if.slave bus
);
   localparam int RIDX = $clog2(NREGS);

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  regs [NREGS];

   logic [3:0]        alucode_q, pc_control_q;
   logic [RIDX-1:0]   rd_q, rs2_q, rt_q;
   logic [IMM_W-1:0]  imm_q;
   logic              im_q, flag_q, mem2_q, wcode_q;
   logic [WIDTH-1:0]  num1_q, num2_q, result_q;
   logic [PC_W-1:0]   pc_q;
   logic              err_q;

   logic [WIDTH-1:0]  rd_val, rs2_val, rt_val, imm_sext;
   logic [WIDTH-1:0]  alu_a, alu_b, alu_y, towrite;
   logic              alu_err;
   logic [PC_W-1:0]   jump;
   logic              take;

   // Out-of-range register indices read as zero.
   always_comb begin
      rd_val  = '0;
      rs2_val = '0;
      rt_val  = '0;
      if (int'(rd_q)  < NREGS) rd_val  = regs[rd_q];
      if (int'(rs2_q) < NREGS) rs2_val = regs[rs2_q];
      if (int'(rt_q)  < NREGS) rt_val  = regs[rt_q];
   end

   assign imm_sext = WIDTH'($signed(imm_q));

   // With only src1 from RAM its data arrives in EXEC; with both, src1 was parked in RD2.
   assign alu_a   = flag_q ? (mem2_q ? num1_q : bus.mem_rdata) : rd_val;
   assign alu_b   = mem2_q ? bus.mem_rdata : (im_q ? imm_sext : rs2_val);
   assign towrite = wcode_q ? num2_q : result_q;

   dp_alu #(.WIDTH(WIDTH)) u_alu (
      .num1    (alu_a),
      .num2    (alu_b),
      .alucode (alucode_q),
      .result  (alu_y),
      .err_op  (alu_err)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      bus.instr_ready = 1'b0;
      bus.done        = 1'b0;
      bus.mem_we      = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_wdata   = '0;
      case (state)
         ST_IDLE: begin
            bus.instr_ready = 1'b1;
            if (bus.instr_valid) begin
               if (bus.flag)                             state_nxt = ST_RD1;
               else if (bus.flag1 && !bus.im_control)    state_nxt = ST_RD2;
               else                                      state_nxt = ST_EXEC;
            end
         end
         ST_RD1: begin
            bus.mem_addr = ADDR_W'(rd_val);
            state_nxt    = mem2_q ? ST_RD2 : ST_EXEC;
         end
         ST_RD2: begin
            bus.mem_addr = ADDR_W'(rs2_val);
            state_nxt    = ST_EXEC;
         end
         ST_EXEC: state_nxt = ST_WB;
         ST_WB: begin
            bus.done  = 1'b1;
            state_nxt = ST_IDLE;
            if (flag_q) begin
               bus.mem_we    = 1'b1;
               bus.mem_addr  = ADDR_W'(rd_val);
               bus.mem_wdata = towrite;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Branches compare the operands frozen at the EXEC edge; rd/rt are still pre-WB here.
   always_comb begin
      take = 1'b0;
      jump = PC_W'(1);
      case (pc_control_q)
         PC_NEXT: ;
         PC_BEQ:  take = (num1_q == num2_q);
         PC_BLT:  take = (num1_q <  num2_q);
         PC_BGT:  take = (num1_q >  num2_q);
         PC_BNE:  take = (num1_q != num2_q);
         PC_BLE:  take = (num1_q <= num2_q);
         PC_BGE:  take = (num1_q >= num2_q);
         PC_BNZ:  take = (num1_q != '0);
         PC_BZ:   take = (num1_q == '0);
         PC_JREG: jump = PC_W'(rd_val);
         PC_HALT: jump = '0;
         default: jump = '0;
      endcase
      if (take) jump = PC_W'(rt_val);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         alucode_q    <= '0;
         pc_control_q <= '0;
         rd_q         <= '0;
         rs2_q        <= '0;
         rt_q         <= '0;
         imm_q        <= '0;
         im_q         <= 1'b0;
         flag_q       <= 1'b0;
         mem2_q       <= 1'b0;
         wcode_q      <= 1'b0;
         num1_q       <= '0;
         num2_q       <= '0;
         result_q     <= '0;
         pc_q         <= '0;
         err_q        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.instr_valid) begin
                  alucode_q    <= bus.alucode;
                  pc_control_q <= bus.pc_control;
                  rd_q         <= bus.rd;
                  rs2_q        <= bus.rs2;
                  rt_q         <= bus.rt;
                  imm_q        <= bus.imm;
                  im_q         <= bus.im_control;
                  flag_q       <= bus.flag;
                  mem2_q       <= bus.flag1 & ~bus.im_control;
                  wcode_q      <= bus.writecode;
               end
            end
            ST_RD2: begin
               if (flag_q) num1_q <= bus.mem_rdata;
            end
            ST_EXEC: begin
               num1_q   <= alu_a;
               num2_q   <= alu_b;
               result_q <= alu_y;
               if (alu_err) err_q <= 1'b1;
            end
            ST_WB: begin
               if (!flag_q && int'(rd_q) < NREGS) regs[rd_q] <= towrite;
               pc_q <= pc_q + jump;
            end
            default: ;
         endcase
      end
   end

   assign bus.PC     = pc_q;
   assign bus.result = result_q;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_dp_multicycle.sv
// Scoreboard bench for dp_multicycle: a behavioural model predicts each instruction's
// completion record, which is queued at issue and compared when done pulses.
module tb_dp_multicycle;
   import dp_pkg::*;

   localparam int WIDTH  = 32;
   localparam int NREGS  = 8;
   localparam int IMM_W  = 21;
   localparam int ADDR_W = 10;
   localparam int PC_W   = 32;

   typedef struct packed {
      logic [31:0] result;
      logic [31:0] pc;
      logic [7:0]  lat;
      logic        we;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic        err;
   } txn_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   dp_multicycle_if #(.WIDTH(WIDTH), .NREGS(NREGS), .IMM_W(IMM_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) bus ();

   dp_multicycle #(.WIDTH(WIDTH), .NREGS(NREGS), .IMM_W(IMM_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] mem [1024];
   always @(posedge clock) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
   end

   logic [31:0] m_regs [8];
   logic [31:0] m_pc;
   logic        m_err;
   txn_t        exp_q[$];
   txn_t        obs_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_pc  = '0;
      m_err = 1'b0;
   endtask

   task automatic run_instr(input logic [3:0] alu, input logic [3:0] pcc, input int rd, input int rs2,
                            input int rt, input logic [20:0] imm, input logic im, input logic fl,
                            input logic fl1, input logic wc);
      logic [31:0] a, b, y, tw, jmp;
      logic        eop;
      txn_t        e, o;
      a   = fl ? mem[m_regs[rd][9:0]] : m_regs[rd];
      b   = im ? {{11{imm[20]}}, imm} : (fl1 ? mem[m_regs[rs2][9:0]] : m_regs[rs2]);
      eop = 1'b0;
      case (alu)
         4'd0:  y = a;
         4'd1:  y = a + b;
         4'd2:  y = a - b;
         4'd3:  y = a * b;
         4'd4:  if (b == 0) begin y = '1; eop = 1'b1; end else y = a / b;
         4'd5:  if (b == 0) begin y = '1; eop = 1'b1; end else y = a % b;
         4'd6:  y = a | b;
         4'd7:  y = a & b;
         4'd8:  y = a ^ b;
         4'd9:  y = ~a;
         4'd10: y = a >> 1;
         4'd11: y = a << 1;
         default: begin y = '1; eop = 1'b1; end
      endcase
`ifndef DP_MULDIV_EN
      if (alu == 4'd3 || alu == 4'd4 || alu == 4'd5) begin y = '1; eop = 1'b1; end
`endif
      tw = wc ? b : y;
      case (pcc)
         4'd0: jmp = 32'd1;
         4'd1: jmp = (a == b) ? m_regs[rt] : 32'd1;
         4'd2: jmp = (a <  b) ? m_regs[rt] : 32'd1;
         4'd3: jmp = (a >  b) ? m_regs[rt] : 32'd1;
         4'd4: jmp = (a != b) ? m_regs[rt] : 32'd1;
         4'd5: jmp = (a <= b) ? m_regs[rt] : 32'd1;
         4'd6: jmp = (a >= b) ? m_regs[rt] : 32'd1;
         4'd7: jmp = (a != 0) ? m_regs[rt] : 32'd1;
         4'd8: jmp = (a == 0) ? m_regs[rt] : 32'd1;
         4'd9: jmp = m_regs[rd];
         default: jmp = 32'd0;
      endcase
      e.result = y;
      e.pc     = m_pc + jmp;
      e.lat    = 8'(2 + int'(fl) + int'(fl1 & ~im));
      e.we     = fl;
      e.addr   = fl ? m_regs[rd][9:0] : 10'd0;
      e.wdata  = fl ? tw : 32'd0;
      e.err    = m_err | eop;
      m_err = e.err;
      m_pc  = e.pc;
      if (!fl) m_regs[rd] = tw;
      exp_q.push_back(e);

      @(negedge clock);
      bus.alucode    = alu;
      bus.pc_control = pcc;
      bus.rd         = 3'(rd);
      bus.rs2        = 3'(rs2);
      bus.rt         = 3'(rt);
      bus.imm        = imm;
      bus.im_control = im;
      bus.flag       = fl;
      bus.flag1      = fl1;
      bus.writecode  = wc;
      bus.instr_valid = 1'b1;
      @(posedge clock);
      #1;
      // Scramble the fields: the DUT must be working from its latched copy.
      bus.instr_valid = 1'b0;
      bus.alucode     = 4'($urandom);
      bus.rd          = 3'($urandom);
      bus.rs2         = 3'($urandom);
      bus.rt          = 3'($urandom);
      bus.imm         = 21'($urandom);
      bus.flag        = 1'($urandom);
      bus.flag1       = 1'($urandom);
      o = '0;
      o.lat = 8'hFF;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clock);
         if (bus.done) begin
            o.lat    = 8'(i);
            o.result = bus.result;
            o.we     = bus.mem_we;
            o.addr   = bus.mem_we ? bus.mem_addr : 10'd0;
            o.wdata  = bus.mem_we ? bus.mem_wdata : 32'd0;
            break;
         end
      end
      @(posedge clock);
      #1;
      o.pc  = bus.PC;
      o.err = bus.err;
      obs_q.push_back(o);
   endtask

   task automatic test_reset();
      bus.instr_valid = 1'b0;
      bus.alucode = '0; bus.pc_control = '0; bus.rd = '0; bus.rs2 = '0; bus.rt = '0;
      bus.imm = '0; bus.im_control = 1'b0; bus.flag = 1'b0; bus.flag1 = 1'b0; bus.writecode = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      model_reset();
      @(negedge clock);
      n_checks++; if (bus.instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.instr_ready); else n_pass++;
      n_checks++; if (bus.PC !== 32'd0) $display("FAIL reset_pc: got %h want 0", bus.PC); else n_pass++;
      n_checks++; if (bus.result !== 32'd0) $display("FAIL reset_result: got %h want 0", bus.result); else n_pass++;
      n_checks++; if ({bus.done, bus.err, bus.mem_we} !== 3'b000)
         $display("FAIL reset_flags: done/err/we got %b want 000", {bus.done, bus.err, bus.mem_we}); else n_pass++;
      n_checks++; if ({bus.mem_addr, bus.mem_wdata} !== 42'd0)
         $display("FAIL reset_mem_port: addr %h wdata %h want 0", bus.mem_addr, bus.mem_wdata); else n_pass++;
   endtask

   task automatic test_add_imm();
      txn_t e, o;
      run_instr(ALU_ADD,  PC_NEXT, 1, 0, 0, 21'd5,       1'b1, 1'b0, 1'b0, 1'b0);
      run_instr(ALU_ADD,  PC_NEXT, 1, 0, 0, 21'h1FFFFF,  1'b1, 1'b0, 1'b0, 1'b0);
      run_instr(ALU_SUB,  PC_NEXT, 1, 0, 0, 21'd5,       1'b1, 1'b0, 1'b0, 1'b0);
      run_instr(ALU_PASS, PC_NEXT, 1, 0, 0, 21'd0,       1'b1, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL add_imm txn: got %p want %p", o, e); else n_pass++;
      end
   endtask

   task automatic test_mem_indirect();
      txn_t e, o;
      mem[10] = 32'd7;
      run_instr(ALU_PASS, PC_NEXT, 2, 0, 0, 21'd10, 1'b1, 1'b0, 1'b0, 1'b1);
      run_instr(ALU_ADD,  PC_NEXT, 2, 0, 0, 21'd3,  1'b1, 1'b1, 1'b0, 1'b0);
      n_checks++; if (mem[10] !== 32'd10) $display("FAIL mem_indirect_ram: got %h want 0000000a", mem[10]); else n_pass++;
      run_instr(ALU_PASS, PC_NEXT, 2, 0, 0, 21'd0,  1'b1, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL mem_indirect txn: got %p want %p", o, e); else n_pass++;
      end
   endtask

   task automatic test_mem_both();
      txn_t e, o;
      mem[4] = 32'd6;
      mem[8] = 32'd9;
      run_instr(ALU_PASS, PC_NEXT, 1, 0, 0, 21'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      run_instr(ALU_PASS, PC_NEXT, 2, 0, 0, 21'd8, 1'b1, 1'b0, 1'b0, 1'b1);
      run_instr(ALU_SUB,  PC_NEXT, 1, 2, 0, 21'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      n_checks++; if (mem[4] !== 32'hFFFFFFFD) $display("FAIL mem_both_ram: got %h want fffffffd", mem[4]); else n_pass++;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL mem_both txn: got %p want %p", o, e); else n_pass++;
      end
   endtask

   task automatic test_branch();
      txn_t e, o;
      run_instr(ALU_PASS, PC_NEXT, 0, 0, 0, 21'd3, 1'b1, 1'b0, 1'b0, 1'b1);
      run_instr(ALU_PASS, PC_NEXT, 1, 0, 0, 21'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      run_instr(ALU_PASS, PC_NEXT, 3, 0, 0, 21'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      run_instr(ALU_PASS, PC_BLT,  0, 1, 3, 21'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_instr(ALU_PASS, PC_NEXT, 0, 0, 0, 21'd9, 1'b1, 1'b0, 1'b0, 1'b1);
      run_instr(ALU_PASS, PC_BLT,  0, 1, 3, 21'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_instr(ALU_PASS, PC_HALT, 0, 1, 3, 21'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_instr(ALU_PASS, PC_JREG, 3, 0, 0, 21'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL branch txn: got %p want %p", o, e); else n_pass++;
      end
   endtask

   task automatic test_err();
      txn_t e, o;
      run_instr(ALU_DIV,  PC_NEXT, 1, 5, 0, 21'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_instr(ALU_ADD,  PC_NEXT, 2, 0, 0, 21'd1, 1'b1, 1'b0, 1'b0, 1'b0);
      run_instr(ALU_PASS, PC_NEXT, 1, 0, 0, 21'd3, 1'b1, 1'b0, 1'b0, 1'b1);
      run_instr(ALU_MUL,  PC_NEXT, 1, 0, 0, 21'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      run_instr(4'd13,    PC_NEXT, 2, 0, 0, 21'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL err txn: got %p want %p", o, e); else n_pass++;
      end
   endtask

   task automatic test_reset_abort();
      txn_t e, o;
      mem[20] = 32'd55;
      run_instr(ALU_PASS, PC_NEXT, 4, 0, 0, 21'd20, 1'b1, 1'b0, 1'b0, 1'b1);
      @(negedge clock);
      bus.alucode = ALU_ADD; bus.pc_control = PC_NEXT; bus.rd = 3'd4; bus.imm = 21'd1;
      bus.im_control = 1'b1; bus.flag = 1'b1; bus.flag1 = 1'b0; bus.writecode = 1'b0;
      bus.instr_valid = 1'b1;
      @(posedge clock);
      #1;
      bus.instr_valid = 1'b0;
      n_checks++; if (bus.mem_addr !== 10'd20) $display("FAIL rd1_addr: got %h want 014", bus.mem_addr); else n_pass++;
      n_checks++; if (bus.instr_ready !== 1'b0) $display("FAIL rd1_busy: got %b want 0", bus.instr_ready); else n_pass++;
      @(negedge clock);
      reset = 1'b1;
      #1;
      n_checks++; if (bus.instr_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", bus.instr_ready); else n_pass++;
      n_checks++; if (bus.mem_we !== 1'b0) $display("FAIL abort_we: got %b want 0", bus.mem_we); else n_pass++;
      n_checks++; if (bus.PC !== 32'd0) $display("FAIL abort_pc: got %h want 0", bus.PC); else n_pass++;
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      repeat (4) @(negedge clock);
      n_checks++; if (mem[20] !== 32'd55) $display("FAIL abort_ram: got %h want 00000037", mem[20]); else n_pass++;
      run_instr(ALU_PASS, PC_NEXT, 4, 0, 0, 21'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL reset_abort txn: got %p want %p", o, e); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_add_imm();
      test_mem_indirect();
      test_mem_both();
      test_branch();
      test_err();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
